// File: rtl/evg_tx_framer.sv
// Event-generator transmit framer.
// Builds the 16-bit GTY character stream: byte 0 carries periodic K28.5 commas
// interleaved with the distributed bus, byte 1 carries one event code per word
// chosen by fixed priority (heartbeat > seconds shift > user FIFO > null).
// Every output is a flop, so inputs sampled at edge N appear after edge N.
module evg_tx_framer #(
    parameter int         COMMA_INTERVAL     = 2,
    parameter int         FIFO_DEPTH         = 16,
    parameter int         HEARTBEAT_INTERVAL = 125000000,
    parameter logic [7:0] HEARTBEAT_CODE     = 8'h7A,
    parameter logic [7:0] SHIFT0_CODE        = 8'h70,
    parameter logic [7:0] SHIFT1_CODE        = 8'h71
) (
    input  logic                          evrTxClk,
    input  logic                          evrTxReset_n,
    input  logic [7:0]                    eventCode,
    input  logic                          eventValid,
    output logic                          eventReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    input  logic [7:0]                    dbus,
    input  logic [31:0]                   seconds,
    input  logic                          secondsValid,
    output logic                          secondsBusy,
    output logic [15:0]                   txChars,
    output logic [1:0]                    txCharIsK
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = $clog2(COMMA_INTERVAL);

    localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(COMMA_INTERVAL - 1);
    localparam logic [31:0]       HB_LAST    = 32'(HEARTBEAT_INTERVAL - 1);
    localparam logic [7:0]        K28_5      = 8'hBC;

    // Word position within the comma period
    logic [WORD_W-1:0] word_q, word_d;

    // Heartbeat timer and the single-entry pending flag
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        hb_pend_q, hb_pend_d;
    logic        hb_term;

    // Seconds shifter: MSB is the next bit to send
    logic [31:0] sh_data_q, sh_data_d;
    logic [4:0]  sh_cnt_q, sh_cnt_d;
    logic        sh_busy_q, sh_busy_d;
    logic        sh_win;

    // User event FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    // Registered line outputs
    logic [15:0] tx_chars_q, tx_chars_d;
    logic [1:0]  tx_k_q, tx_k_d;

    // Next-state logic: comma slotting, byte-1 arbitration, timers, FIFO bookkeeping
    always_comb begin
        word_d     = (word_q == WORD_LAST) ? '0 : word_q + WORD_W'(1);
        hb_cnt_d   = hb_cnt_q;
        hb_pend_d  = hb_pend_q;
        hb_term    = 1'b0;
        sh_data_d  = sh_data_q;
        sh_cnt_d   = sh_cnt_q;
        sh_busy_d  = sh_busy_q;
        sh_win     = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        pop        = 1'b0;
        tx_chars_d = 16'h0000;
        tx_k_d     = 2'b00;

        // Byte 0: comma on the first word of each period, bus data otherwise
        if (word_q == '0) begin
            tx_chars_d[7:0] = K28_5;
            tx_k_d[0]       = 1'b1;
        end else begin
            tx_chars_d[7:0] = dbus;
        end

        // Byte 1: one winner per word, never a K character
        if (hb_pend_q) begin
            tx_chars_d[15:8] = HEARTBEAT_CODE;
            hb_pend_d        = 1'b0;
        end else if (sh_busy_q) begin
            sh_win           = 1'b1;
            tx_chars_d[15:8] = sh_data_q[31] ? SHIFT1_CODE : SHIFT0_CODE;
        end else if (level_q != '0) begin
            pop              = 1'b1;
            tx_chars_d[15:8] = fifo_mem[rd_ptr_q];
        end

        // Heartbeat timer; a terminal count while pending simply re-sets the flag
        if (HEARTBEAT_INTERVAL != 0) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_term  = 1'b1;
            end else begin
                hb_cnt_d = hb_cnt_q + 32'd1;
            end
        end
        if (hb_term) begin
            hb_pend_d = 1'b1;
        end

        // Seconds shifter: advance on a won slot, load only when idle
        if (sh_win) begin
            sh_data_d = {sh_data_q[30:0], 1'b0};
            sh_cnt_d  = sh_cnt_q + 5'd1;
            if (sh_cnt_q == 5'd31) begin
                sh_busy_d = 1'b0;
            end
        end else if (!sh_busy_q && secondsValid) begin
            sh_data_d = seconds;
            sh_cnt_d  = 5'd0;
            sh_busy_d = 1'b1;
        end

        // FIFO: null codes are handshaken but never stored
        push = eventValid && ready_q && (eventCode != 8'h00);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
        ready_d = (level_d != FULL_LEVEL);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge evrTxClk) begin
        if (!evrTxReset_n) begin
            word_q     <= '0;
            hb_cnt_q   <= '0;
            hb_pend_q  <= 1'b0;
            sh_data_q  <= '0;
            sh_cnt_q   <= '0;
            sh_busy_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            tx_chars_q <= 16'h00BC;
            tx_k_q     <= 2'b01;
        end else begin
            word_q     <= word_d;
            hb_cnt_q   <= hb_cnt_d;
            hb_pend_q  <= hb_pend_d;
            sh_data_q  <= sh_data_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_busy_q  <= sh_busy_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            tx_chars_q <= tx_chars_d;
            tx_k_q     <= tx_k_d;
        end
    end

    // FIFO storage write port; contents need no reset since pointers define validity
    always_ff @(posedge evrTxClk) begin
        if (evrTxReset_n && push) begin
            fifo_mem[wr_ptr_q] <= eventCode;
        end
    end

    assign txChars     = tx_chars_q;
    assign txCharIsK   = tx_k_q;
    assign eventReady  = ready_q;
    assign fifoLevel   = level_q;
    assign secondsBusy = sh_busy_q;

endmodule
